// File: rtl/cpu_uart_pkg.sv
// Shared types and constants for the CPU hex UART transmitter.
// Holds the frame FSM states, UART line levels and the nibble-to-ASCII helper.
package cpu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41 - 8'd10;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;

    // Upper-case hex digit for a 4-bit value.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        logic [7:0] wide;
        wide = {4'h0, nibble};
        if (nibble < 4'd10) begin
            return ASCII_DIGIT_BASE + wide;
        end
        return ASCII_ALPHA_BASE + wide;
    endfunction

endpackage

// File: rtl/sync_nibble_fifo.sv
// Small synchronous FIFO buffering CPU output nibbles.
// A full FIFO still accepts a push when a pop happens on the same edge.
module sync_nibble_fifo #(
    parameter int unsigned DATA_WIDTH      = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_ADDR_WIDTH:0]   level
);

    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]   LVL_ONE = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]   LVL_FULL =
        (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   level_q;
    logic                       do_push;
    logic                       do_pop;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_ONE;
            end
        end
    end

endmodule

// File: rtl/cpu_hex_uart_tx.sv
// Logs CPU output nibbles as ASCII hex characters on a UART 8N1 TX line.
// Frames are sent back-to-back while the nibble FIFO holds data.
module cpu_hex_uart_tx
    import cpu_uart_pkg::*;
#(
    parameter int unsigned UART_DATA_LENGTH           = 8,
    parameter int unsigned BAUD_COUNTS_PER_BIT        = 521,
    parameter int unsigned BAUD_RATE_COUNTER_BITWIDTH = 10,
    parameter int unsigned DATA_WIDTH                 = 4,
    parameter int unsigned FIFO_DEPTH                 = 4,
    parameter int unsigned FIFO_ADDR_WIDTH            = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_strb_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int unsigned BW = BAUD_RATE_COUNTER_BITWIDTH;
    localparam int unsigned NW = $clog2(UART_DATA_LENGTH);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNTS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = 1;
    localparam logic [NW-1:0] BIT_LAST  = NW'(UART_DATA_LENGTH - 1);
    localparam logic [NW-1:0] BIT_ONE   = 1;

    uart_state_e state_q, state_d;

    logic [BW-1:0]               baud_q, baud_d;
    logic [NW-1:0]               bit_q, bit_d;
    logic [UART_DATA_LENGTH-1:0] shift_q, shift_d;
    logic                        tx_q, tx_d;
    logic                        strb_q;
    logic                        overflow_q;

    logic                        push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [FIFO_ADDR_WIDTH:0]    fifo_level;
    logic [DATA_WIDTH-1:0]       fifo_rdata;
    logic [UART_DATA_LENGTH-1:0] ascii_byte;
    logic                        baud_done;

    assign push       = data_valid_strb_i && !strb_q;
    assign ascii_byte = UART_DATA_LENGTH'(hex_to_ascii(4'(fifo_rdata)));
    assign baud_done  = (baud_q == BAUD_LAST);

    sync_nibble_fifo #(
        .DATA_WIDTH      (DATA_WIDTH),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (push),
        .pop      (fifo_pop),
        .wdata    (data_i),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d   = UART_IDLE_LEVEL;
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = ascii_byte;
                    tx_d     = UART_START_BIT;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = UART_STOP_BIT;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = ascii_byte;
                        tx_d     = UART_START_BIT;
                        state_d  = START;
                    end else begin
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            strb_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            strb_q  <= data_valid_strb_i;
            if (push && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx_o       = tx_q;
    assign overflow_o = overflow_q;
    assign busy_o     = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: doc/cpu_hex_uart_tx.md
Name: cpu_hex_uart_tx

Overview:
Downstream consumer of the CPU output port (out_pins_o / data_valid_strb_o).
- Each 4-bit output value is captured into a small FIFO.
- Each captured value is converted to one ASCII hex character and sent as a UART 8N1 frame on a single TX pin.
- The block lets a host terminal log program output at the same baud rate the programmer's UART RX uses.

Parameters:
UART_DATA_LENGTH, 8, data bits per frame (LSB first)
BAUD_COUNTS_PER_BIT, 521, clocks per UART bit (10 MHz clock)
BAUD_RATE_COUNTER_BITWIDTH, 10, baud counter width; must satisfy 2^width >= BAUD_COUNTS_PER_BIT
DATA_WIDTH, 4, CPU output nibble width
FIFO_DEPTH, 4, buffered nibbles; must be a power of two
FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous, active-low reset
data_i  in  DATA_WIDTH  CPU output value (out_pins_o)
data_valid_strb_i  in  1  CPU output-valid strobe (data_valid_strb_o)
tx_o  out  1  UART TX line; idle high
busy_o  out  1  high while a frame is on the line or the FIFO is non-empty
overflow_o  out  1  sticky flag: a value was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - tx_o=1, busy_o=0, overflow_o=0
  - FIFO empty; state IDLE; baud and bit counters 0; strobe history register 0
- Reset mid-frame aborts the frame immediately: tx_o returns high and the FIFO contents are lost.
- Capture: push on a rising edge of data_valid_strb_i only. A push occurs when the strobe is 1 this cycle and the history register is 0.
  - The strobe held high for several cycles produces exactly one push.
  - data_i is sampled on the same edge as the push.
- FIFO full and a push with no pop on the same edge: the value is dropped and overflow_o is set to 1 on that edge; it is cleared only by reset.
- FIFO full with push and pop on the same edge: both are accepted; the level is unchanged and there is no overflow.
- Pointers wrap modulo FIFO_DEPTH. A level counter of width FIFO_ADDR_WIDTH+1 distinguishes full from empty.
- Conversion: nibble 0..9 maps to 8'h30..8'h39; nibble 10..15 maps to 8'h41..8'h46 (upper-case).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty, on the next edge: pop, load the shift register with the ASCII byte, set tx_o=0, go to START.
  - START: hold tx_o=0 for BAUD_COUNTS_PER_BIT clocks, then drive bit0 and go to DATA.
  - DATA: each bit is held BAUD_COUNTS_PER_BIT clocks, shifted out LSB first. After bit UART_DATA_LENGTH-1, drive tx_o=1 and go to STOP.
  - STOP: hold tx_o=1 for BAUD_COUNTS_PER_BIT clocks. At the end:
    - FIFO non-empty: pop and go directly to START (back-to-back, no idle gap).
    - FIFO empty: go to IDLE.
- Baud counter runs 0..BAUD_COUNTS_PER_BIT-1 and resets on every bit transition. A frame is exactly (UART_DATA_LENGTH+2)*BAUD_COUNTS_PER_BIT clocks.
- Latency: for a strobe rising edge sampled at edge N with the FIFO empty and FSM in IDLE:
  - the push lands at edge N
  - tx_o falls at edge N+1
- tx_o is driven directly from a register (glitch-free).
- busy_o = (state != IDLE) || (FIFO level != 0). It is registered-consistent with the state and level and has no combinational path from the inputs.

Decomposition:
- Shared package cpu_uart_pkg holds:
  - the FSM state typedef (IDLE, START, DATA, STOP)
  - ASCII_DIGIT_BASE = 8'h30
  - ASCII_ALPHA_BASE = 8'h41 - 10
  - UART_IDLE_LEVEL = 1'b1
  - the UART_START_BIT and UART_STOP_BIT constants
- One sub-module, sync_nibble_fifo (parameters DATA_WIDTH, FIFO_DEPTH, FIFO_ADDR_WIDTH; ports push/pop/full/empty/level), which the top-level FSM instantiates.

Test Plan:
All scenarios use BAUD_COUNTS_PER_BIT=4, so one frame is 40 clocks.
1. Reset, then idle 100 clocks -> tx_o=1, busy_o=0, overflow_o=0 throughout.
2. Strobe pulse with data_i=4'hA -> tx_o falls 1 clock after the push edge; sampled mid-bit sequence is 0, 1,0,0,0,0,0,1,0, 1 (byte 8'h41); busy_o drops at frame end.
3. Strobe held high 10 cycles with data_i=4'h3 -> exactly one frame of 8'h33; no second frame.
4. Back-to-back: 4'h0, 4'h9, 4'hF pulsed 2 clocks apart -> frames 8'h30, 8'h39, 8'h46 contiguous with no idle between stop and start bits (120 clocks total).
5. Overflow: 6 pulses (values 1..6) during the first frame -> the first value is in flight and values 2..5 are buffered; value 6 is dropped, overflow_o=1; output is "12345"; overflow_o stays 1 until reset.
6. Assert reset_ni=0 mid data bit of a frame -> tx_o=1 asynchronously, busy_o=0, FIFO empty; after release, no residual frame is sent.
